// File: rtl/axil_reg_bank_if.sv
// AXI-Lite bus bundle (32-bit address and data) shared by the UDP bridge master and the register bank.
interface AXIL_IF;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport Slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport Master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI-Lite register bank: NUM_RW control registers out to fabric, NUM_RO status words read back.
// Optional per-register write strobe output enabled by defining AXIL_REG_BANK_WRITE_PULSE_EN.
module axil_reg_bank #(
    parameter int          NUM_RW    = 16,
    parameter int          NUM_RO    = 16,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                                     clk,
    input  logic                                     reset,
    AXIL_IF.Slave                                    axil_if,
    output logic [NUM_RW*32-1:0]                     ctrl_out,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] status_in,
`ifdef AXIL_REG_BANK_WRITE_PULSE_EN
    output logic [NUM_RW-1:0]                        wr_pulse,
`endif
    output logic                                     w_state_dbg,
    output logic                                     r_state_dbg
);

    // Handshake rule on every channel: a beat transfers on the rising edge where valid and ready
    // are both high; a raised valid and its payload stay put until that edge.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_RESP } r_state_t;

    w_state_t    w_state_q, w_state_d;
    r_state_t    r_state_q, r_state_d;
    logic        aw_have_q, aw_have_d, w_have_q, w_have_d;
    logic [29:0] aw_addr_q, aw_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        awready_q, awready_d, wready_q, wready_d;
    logic        bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] regs_q [NUM_RW];
    logic [31:0] regs_d [NUM_RW];
`ifdef AXIL_REG_BANK_WRITE_PULSE_EN
    logic [NUM_RW-1:0] wr_pulse_q, wr_pulse_d;
`endif

    logic        aw_hs, w_hs, ar_hs, aw_ok, w_ok;
    logic [29:0] wr_idx, rd_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        unused_ok;

    assign unused_ok = ^{axil_if.awprot, axil_if.arprot, axil_if.awaddr[1:0], axil_if.araddr[1:0]};

    // Write channel: capture AW and W independently; commit once both are held.
    always_comb begin
        w_state_d = w_state_q;
        aw_have_d = aw_have_q;
        w_have_d  = w_have_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
`ifdef AXIL_REG_BANK_WRITE_PULSE_EN
        wr_pulse_d = '0;
`endif
        aw_hs   = axil_if.awvalid & awready_q;
        w_hs    = axil_if.wvalid & wready_q;
        aw_ok   = aw_have_q | aw_hs;
        w_ok    = w_have_q | w_hs;
        wr_idx  = aw_hs ? axil_if.awaddr[31:2] : aw_addr_q;
        wr_data = w_hs ? axil_if.wdata : w_data_q;
        wr_strb = w_hs ? axil_if.wstrb : w_strb_q;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) aw_addr_d = axil_if.awaddr[31:2];
                if (w_hs) begin
                    w_data_d = axil_if.wdata;
                    w_strb_d = axil_if.wstrb;
                end
                if (aw_ok && w_ok) begin
                    w_state_d = W_RESP;
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = RESP_SLVERR;
                    for (int k = 0; k < NUM_RW; k++) begin
                        if (wr_idx == 30'(k)) begin
                            bresp_d = RESP_OKAY;
                            for (int b = 0; b < 4; b++) begin
                                if (wr_strb[b]) regs_d[k][8*b +: 8] = wr_data[8*b +: 8];
                            end
`ifdef AXIL_REG_BANK_WRITE_PULSE_EN
                            wr_pulse_d[k] = |wr_strb;
`endif
                        end
                    end
                end else begin
                    aw_have_d = aw_ok;
                    w_have_d  = w_ok;
                    awready_d = !aw_ok;
                    wready_d  = !w_ok;
                end
            end
            W_RESP: begin
                if (axil_if.bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read channel samples regs_q, so a same-edge write is not yet visible.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        ar_hs     = axil_if.arvalid & arready_q;
        rd_idx    = axil_if.araddr[31:2];

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_RESP;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = 32'h0;
                    rresp_d   = RESP_SLVERR;
                    for (int k = 0; k < NUM_RW; k++) begin
                        if (rd_idx == 30'(k)) begin
                            rdata_d = regs_q[k];
                            rresp_d = RESP_OKAY;
                        end
                    end
                    for (int j = 0; j < NUM_RO; j++) begin
                        if (rd_idx == 30'(NUM_RW + j)) begin
                            rdata_d = status_in[32*j +: 32];
                            rresp_d = RESP_OKAY;
                        end
                    end
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_RESP: begin
                if (axil_if.rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int k = 0; k < NUM_RW; k++) regs_q[k] <= RESET_VAL;
`ifdef AXIL_REG_BANK_WRITE_PULSE_EN
            wr_pulse_q <= '0;
`endif
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
`ifdef AXIL_REG_BANK_WRITE_PULSE_EN
            wr_pulse_q <= wr_pulse_d;
`endif
        end
    end

    always_comb begin
        ctrl_out = '0;
        for (int k = 0; k < NUM_RW; k++) ctrl_out[32*k +: 32] = regs_q[k];
    end

    assign axil_if.awready = awready_q;
    assign axil_if.wready  = wready_q;
    assign axil_if.bvalid  = bvalid_q;
    assign axil_if.bresp   = bresp_q;
    assign axil_if.arready = arready_q;
    assign axil_if.rvalid  = rvalid_q;
    assign axil_if.rdata   = rdata_q;
    assign axil_if.rresp   = rresp_q;
    assign w_state_dbg     = (w_state_q == W_RESP);
    assign r_state_dbg     = (r_state_q == R_RESP);
`ifdef AXIL_REG_BANK_WRITE_PULSE_EN
    assign wr_pulse = wr_pulse_q;
`endif

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank (4 RW regs, 2 RO words); pulse checks when AXIL_REG_BANK_WRITE_PULSE_EN is set.
module tb_axil_reg_bank;
  localparam int NUM_RW = 4;
  localparam int NUM_RO = 2;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  AXIL_IF bus();
  logic [NUM_RW*32-1:0] ctrl_out;
  logic [NUM_RO*32-1:0] status_in;
  logic w_state_dbg, r_state_dbg;
`ifdef AXIL_REG_BANK_WRITE_PULSE_EN
  logic [NUM_RW-1:0] wr_pulse;
`endif

  axil_reg_bank #(.NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .RESET_VAL(32'h0)) dut (
    .clk(clk),
    .reset(reset),
    .axil_if(bus),
    .ctrl_out(ctrl_out),
    .status_in(status_in),
`ifdef AXIL_REG_BANK_WRITE_PULSE_EN
    .wr_pulse(wr_pulse),
`endif
    .w_state_dbg(w_state_dbg),
    .r_state_dbg(r_state_dbg)
  );

  // scoreboard
  int n_total = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl[NUM_RW];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_ctrl();
    for (int k = 0; k < NUM_RW; k++) check($sformatf("ctrl_reg%0d", k), ctrl_out[32*k +: 32], mdl[k]);
  endtask

  // driver tasks: each returns 1 time unit after a rising edge
  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    while (!(bus.awready && bus.wready) && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) check("aw_w_timeout", 32'(bus.awready & bus.wready), 32'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic wait_b(input logic [1:0] exp_resp, input int stall);
    int n = 0;
    bus.bready = 1'b0;
    while (bus.bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) check("b_timeout", 32'(bus.bvalid), 32'd1);
    for (int i = 0; i < stall; i++) begin
      check("b_stall_valid", 32'(bus.bvalid), 32'd1);
      check("b_stall_resp", 32'(bus.bresp), 32'(exp_resp));
      check("b_stall_awready", 32'(bus.awready), 32'd0);
      check("b_stall_wready", 32'(bus.wready), 32'd0);
      @(posedge clk); #1;
    end
    check("bresp", 32'(bus.bresp), 32'(exp_resp));
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check("b_done", 32'(bus.bvalid), 32'd0);
    check("aw_reopen", 32'(bus.awready), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] exp_resp);
    send_aw_w(addr, data, strb);
    check("b_latency", 32'(bus.bvalid), 32'd1);
    wait_b(exp_resp, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                         input int stall);
    int n = 0;
    logic [31:0] got;
    bus.araddr = addr; bus.arvalid = 1'b1;
    while (bus.arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) check("ar_timeout", 32'(bus.arready), 32'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    check("r_latency", 32'(bus.rvalid), 32'd1);
    exp_q.push_back(exp_data);
    for (int i = 0; i < stall; i++) begin
      check("r_stall_valid", 32'(bus.rvalid), 32'd1);
      check("r_stall_data", bus.rdata, exp_data);
      check("r_stall_arready", 32'(bus.arready), 32'd0);
      @(posedge clk); #1;
    end
    got = bus.rdata;
    check("rdata", got, exp_q.pop_front());
    check("rresp", 32'(bus.rresp), 32'(exp_resp));
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    check("r_done", 32'(bus.rvalid), 32'd0);
    check("ar_reopen", 32'(bus.arready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0; bus.rready = 0;
    status_in = {32'h12345678, 32'hCAFEF00D};
    for (int k = 0; k < NUM_RW; k++) mdl[k] = 32'h0;

    // reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_wready", 32'(bus.wready), 32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check_ctrl();
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_awready", 32'(bus.awready), 32'd1);
    check("idle_wready", 32'(bus.wready), 32'd1);
    check("idle_arready", 32'(bus.arready), 32'd1);

    // AW and W in the same cycle
    do_write(32'h4, 32'hDEADBEEF, 4'hF, OKAY);
    mdl[1] = 32'hDEADBEEF;
    check_ctrl();
    do_read(32'h4, 32'hDEADBEEF, OKAY, 0);

    // W leads AW by three cycles
    bus.wdata = 32'h11223344; bus.wstrb = 4'h3; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    repeat (3) begin
      check("wfirst_no_b", 32'(bus.bvalid), 32'd0);
      check("wfirst_wready", 32'(bus.wready), 32'd0);
      check("wfirst_awready", 32'(bus.awready), 32'd1);
      @(posedge clk); #1;
    end
    bus.awaddr = 32'h0; bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    check("wfirst_b_latency", 32'(bus.bvalid), 32'd1);
    wait_b(OKAY, 0);
    mdl[0] = 32'h00003344;
    check_ctrl();

    // partial and empty strobes
    do_write(32'h4, 32'hAABBCCDD, 4'h6, OKAY);
    mdl[1] = 32'hDEBBCCEF;
    do_write(32'h0, 32'hFFFFFFFF, 4'h0, OKAY);
    check_ctrl();

    // RO window and out-of-range
    do_read(32'h10, 32'hCAFEF00D, OKAY, 0);
    do_read(32'h14, 32'h12345678, OKAY, 0);
    do_write(32'h10, 32'hFFFFFFFF, 4'hF, SLVERR);
    do_write(32'h100, 32'hFFFFFFFF, 4'hF, SLVERR);
    check_ctrl();
    do_read(32'h18, 32'h0, SLVERR, 0);
    do_read(32'h7, 32'hDEBBCCEF, OKAY, 0);

    // backpressure on B with a second write waiting
    send_aw_w(32'hC, 32'h00000055, 4'hF);
    mdl[3] = 32'h00000055;
    bus.awaddr = 32'h8; bus.awvalid = 1'b1;
    bus.wdata = 32'h00000066; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    wait_b(OKAY, 10);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("second_b_latency", 32'(bus.bvalid), 32'd1);
    wait_b(OKAY, 0);
    mdl[2] = 32'h00000066;
    check_ctrl();
    do_read(32'hC, 32'h00000055, OKAY, 10);

    // same-edge read and write of reg0: read sees the old value
    bus.araddr = 32'h0; bus.arvalid = 1'b1;
    bus.awaddr = 32'h0; bus.awvalid = 1'b1;
    bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("same_rvalid", 32'(bus.rvalid), 32'd1);
    check("same_bvalid", 32'(bus.bvalid), 32'd1);
    check("same_rd_old", bus.rdata, 32'h00003344);
    mdl[0] = 32'hA5A5A5A5;
    check_ctrl();
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    check("same_b_done", 32'(bus.bvalid), 32'd0);
    check("same_r_done", 32'(bus.rvalid), 32'd0);

`ifdef AXIL_REG_BANK_WRITE_PULSE_EN
    send_aw_w(32'h8, 32'h00000077, 4'hF);
    check("pulse_reg2", 32'(wr_pulse), 32'h4);
    @(posedge clk); #1;
    check("pulse_gone", 32'(wr_pulse), 32'h0);
    wait_b(OKAY, 0);
    mdl[2] = 32'h00000077;
    send_aw_w(32'h8, 32'hFFFFFFFF, 4'h0);
    check("pulse_strb0", 32'(wr_pulse), 32'h0);
    wait_b(OKAY, 0);
    check_ctrl();
`endif

    // reset with both responses pending
    send_aw_w(32'h4, 32'h00000012, 4'hF);
    bus.araddr = 32'h0; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    check("pre_rst_bvalid", 32'(bus.bvalid), 32'd1);
    check("pre_rst_rvalid", 32'(bus.rvalid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("mid_rst_awready", 32'(bus.awready), 32'd0);
    check("mid_rst_arready", 32'(bus.arready), 32'd0);
    for (int k = 0; k < NUM_RW; k++) mdl[k] = 32'h0;
    check_ctrl();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.bready = 1'b1; bus.rready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("post_rst_bvalid", 32'(bus.bvalid), 32'd0);
      check("post_rst_rvalid", 32'(bus.rvalid), 32'd0);
    end
    bus.bready = 1'b0; bus.rready = 1'b0;
    do_write(32'h8, 32'h0BADF00D, 4'hF, OKAY);
    mdl[2] = 32'h0BADF00D;
    check_ctrl();
    do_read(32'h8, 32'h0BADF00D, OKAY, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
